// File: rtl/mu0_sequencer.sv
// mu0_sequencer: phase sequencer for the MU0 CPU.
// Produces one-hot FETCH/EXEC1/EXEC2 strobes and inserts instruction-memory
// wait cycles during fetch. It halts on STP and supports free-run and
// single-step control. It also keeps saturating cycle and retired-instruction
// counters.
module mu0_sequencer #(
    parameter int unsigned MEM_WAIT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             RUN,
    input  logic             STEP,
    input  logic [3:0]       IR_OP,
    input  logic             EXTRA,
    output logic             FETCH,
    output logic             EXEC1,
    output logic             EXEC2,
    output logic             IR_LOAD,
    output logic             HALTED,
    output logic [CNT_W-1:0] CYCLE_CNT,
    output logic [CNT_W-1:0] INSTR_CNT
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC1 = 3'd2,
        ST_EXEC2 = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    localparam logic [3:0]       OP_STP    = 4'b0111;
    localparam logic [3:0]       WAIT_LAST = 4'(MEM_WAIT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [3:0]       wait_q, wait_d;
    logic             step_q;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instr_q, instr_d;
    logic             fetch_q, fetch_d;
    logic             exec1_q, exec1_d;
    logic             exec2_q, exec2_d;
    logic             ir_load_q, ir_load_d;
    logic             halted_q, halted_d;

    logic step_req;
    logic retire;
    logic active;

    assign step_req = STEP & ~step_q;

    // Next-state, wait counter, retire detection and counter updates.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        retire  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (RUN || step_req) begin
                    state_d = ST_FETCH;
                    wait_d  = 4'd0;
                end
            end
            ST_FETCH: begin
                // Stay in fetch until the memory latency has elapsed.
                if (wait_q == WAIT_LAST) begin
                    state_d = ST_EXEC1;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            ST_EXEC1: begin
                if (IR_OP == OP_STP) begin
                    state_d = ST_HALT;
                end else if (EXTRA) begin
                    state_d = ST_EXEC2;
                end else begin
                    retire = 1'b1;
                end
            end
            ST_EXEC2: begin
                retire = 1'b1;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A retiring instruction always completes. RUN only selects what happens next.
        if (retire) begin
            state_d = RUN ? ST_FETCH : ST_IDLE;
            wait_d  = 4'd0;
        end

        active = (state_q == ST_FETCH) || (state_q == ST_EXEC1) || (state_q == ST_EXEC2);

        cycle_d = cycle_q;
        if (active && (cycle_q != CNT_MAX)) begin
            cycle_d = cycle_q + 1'b1;
        end

        instr_d = instr_q;
        if (retire && (instr_q != CNT_MAX)) begin
            instr_d = instr_q + 1'b1;
        end

        // Outputs are registered images of the next state, so they equal a
        // Moore decode of the state register.
        fetch_d   = (state_d == ST_FETCH);
        exec1_d   = (state_d == ST_EXEC1);
        exec2_d   = (state_d == ST_EXEC2);
        halted_d  = (state_d == ST_HALT);
        ir_load_d = (state_d == ST_FETCH) && (wait_d == WAIT_LAST);
    end

    // State, counters and registered strobes. Reset overrides every state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            wait_q    <= 4'd0;
            step_q    <= 1'b0;
            cycle_q   <= '0;
            instr_q   <= '0;
            fetch_q   <= 1'b0;
            exec1_q   <= 1'b0;
            exec2_q   <= 1'b0;
            ir_load_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            step_q    <= STEP;
            cycle_q   <= cycle_d;
            instr_q   <= instr_d;
            fetch_q   <= fetch_d;
            exec1_q   <= exec1_d;
            exec2_q   <= exec2_d;
            ir_load_q <= ir_load_d;
            halted_q  <= halted_d;
        end
    end

    assign FETCH     = fetch_q;
    assign EXEC1     = exec1_q;
    assign EXEC2     = exec2_q;
    assign IR_LOAD   = ir_load_q;
    assign HALTED    = halted_q;
    assign CYCLE_CNT = cycle_q;
    assign INSTR_CNT = instr_q;

endmodule

// File: tb/tb_mu0_sequencer.sv
// Directed testbench for mu0_sequencer.
// Three instances are used: the default parameters, MEM_WAIT=0, and CNT_W=4.
module tb_mu0_sequencer;

    localparam logic [3:0] P_I  = 4'b0000;
    localparam logic [3:0] P_F  = 4'b0001;
    localparam logic [3:0] P_E1 = 4'b0010;
    localparam logic [3:0] P_E2 = 4'b0100;
    localparam logic [3:0] P_H  = 4'b1000;
    localparam logic [3:0] OP_LDI = 4'b1000;
    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_STP = 4'b0111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    logic step = 1'b0;
    logic [3:0] ir_op = 4'b1000;
    logic extra = 1'b0;

    logic fetch, exec1, exec2, ir_load, halted;
    logic [15:0] cycle_cnt, instr_cnt;

    logic mw_fetch, mw_exec1, mw_exec2, mw_ir_load, mw_halted;
    logic [15:0] mw_cycle_cnt, mw_instr_cnt;

    logic sat_rst = 1'b1;
    logic sat_run = 1'b0;
    logic sat_step = 1'b0;
    logic sat_fetch, sat_exec1, sat_exec2, sat_ir_load, sat_halted;
    logic [3:0] sat_cycle_cnt, sat_instr_cnt;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mu0_sequencer u_dut (
        .CLK(clk), .RESET(rst), .RUN(run), .STEP(step), .IR_OP(ir_op), .EXTRA(extra),
        .FETCH(fetch), .EXEC1(exec1), .EXEC2(exec2), .IR_LOAD(ir_load), .HALTED(halted),
        .CYCLE_CNT(cycle_cnt), .INSTR_CNT(instr_cnt)
    );

    mu0_sequencer #(.MEM_WAIT(0), .CNT_W(16)) u_mw0 (
        .CLK(clk), .RESET(rst), .RUN(run), .STEP(step), .IR_OP(ir_op), .EXTRA(extra),
        .FETCH(mw_fetch), .EXEC1(mw_exec1), .EXEC2(mw_exec2), .IR_LOAD(mw_ir_load),
        .HALTED(mw_halted), .CYCLE_CNT(mw_cycle_cnt), .INSTR_CNT(mw_instr_cnt)
    );

    mu0_sequencer #(.MEM_WAIT(1), .CNT_W(4)) u_sat (
        .CLK(clk), .RESET(sat_rst), .RUN(sat_run), .STEP(sat_step), .IR_OP(ir_op),
        .EXTRA(extra), .FETCH(sat_fetch), .EXEC1(sat_exec1), .EXEC2(sat_exec2),
        .IR_LOAD(sat_ir_load), .HALTED(sat_halted), .CYCLE_CNT(sat_cycle_cnt),
        .INSTR_CNT(sat_instr_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        step = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] ph;
        do_reset();
        ph = {halted, exec2, exec1, fetch};
        n_checks++;
        if (ph !== P_I) begin
            n_fail++;
            $display("FAIL reset_phase: got %b expected %b", ph, P_I);
        end
        n_checks++;
        if (ir_load !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ir_load: got %b expected 0", ir_load);
        end
        n_checks++;
        if (cycle_cnt !== 16'd0 || instr_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got cyc=%0d ins=%0d expected 0 0", cycle_cnt, instr_cnt);
        end
        $display("test_reset: phase=%b cyc=%0d ins=%0d", ph, cycle_cnt, instr_cnt);
    endtask

    task automatic test_run_program();
        logic [3:0] exp_ph [10];
        logic [3:0] ph;
        int irl_count;
        exp_ph = '{P_F, P_F, P_E1, P_F, P_F, P_E1, P_F, P_F, P_E1, P_H};
        irl_count = 0;
        do_reset();
        run = 1'b1;
        ir_op = OP_LDI;
        extra = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            // Present STP only once the third instruction is being fetched.
            if (i == 6) ir_op = OP_STP;
            ph = {halted, exec2, exec1, fetch};
            if (ir_load === 1'b1) irl_count++;
            n_checks++;
            if (ph !== exp_ph[i]) begin
                n_fail++;
                $display("FAIL prog_phase[%0d]: got %b expected %b", i, ph, exp_ph[i]);
            end
            $display("test_run_program cycle %0d: phase=%b ir_load=%b", i, ph, ir_load);
        end
        n_checks++;
        if (halted !== 1'b1 || instr_cnt !== 16'd2 || cycle_cnt !== 16'd9) begin
            n_fail++;
            $display("FAIL prog_final: got halted=%b ins=%0d cyc=%0d expected 1 2 9", halted, instr_cnt, cycle_cnt);
        end
        n_checks++;
        if (irl_count != 3) begin
            n_fail++;
            $display("FAIL prog_ir_load_count: got %0d expected 3", irl_count);
        end
        // HALT is absorbing: RUN and STEP are ignored and the counters hold.
        run = 1'b0;
        step = 1'b1;
        tick();
        step = 1'b0;
        run = 1'b1;
        tick();
        tick();
        ph = {halted, exec2, exec1, fetch};
        n_checks++;
        if (ph !== P_H || cycle_cnt !== 16'd9 || instr_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL halt_sticky: got phase=%b cyc=%0d ins=%0d expected %b 9 2", ph, cycle_cnt, instr_cnt, P_H);
        end
        $display("test_run_program halt hold: phase=%b cyc=%0d ins=%0d", ph, cycle_cnt, instr_cnt);
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_ph [6];
        logic [3:0] exp_mw [6];
        logic exp_irl [6];
        logic exp_mw_irl [6];
        logic [3:0] ph, mw_ph;
        exp_ph = '{P_F, P_F, P_E1, P_F, P_F, P_E1};
        exp_mw = '{P_F, P_E1, P_F, P_E1, P_F, P_E1};
        exp_irl = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_mw_irl = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        run = 1'b1;
        ir_op = OP_LDI;
        extra = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            ph = {halted, exec2, exec1, fetch};
            mw_ph = {mw_halted, mw_exec2, mw_exec1, mw_fetch};
            n_checks++;
            if (ph !== exp_ph[i] || ir_load !== exp_irl[i]) begin
                n_fail++;
                $display("FAIL b2b_main[%0d]: got %b/%b expected %b/%b", i, ph, ir_load, exp_ph[i], exp_irl[i]);
            end
            n_checks++;
            if (mw_ph !== exp_mw[i] || mw_ir_load !== exp_mw_irl[i]) begin
                n_fail++;
                $display("FAIL b2b_mw0[%0d]: got %b/%b expected %b/%b", i, mw_ph, mw_ir_load, exp_mw[i], exp_mw_irl[i]);
            end
            $display("test_back_to_back cycle %0d: main=%b mw0=%b", i, ph, mw_ph);
        end
        n_checks++;
        if (instr_cnt !== 16'd1 || cycle_cnt !== 16'd5 || mw_instr_cnt !== 16'd2 || mw_cycle_cnt !== 16'd5) begin
            n_fail++;
            $display("FAIL b2b_counts: got main %0d/%0d mw0 %0d/%0d expected 1/5 2/5", instr_cnt, cycle_cnt, mw_instr_cnt, mw_cycle_cnt);
        end
        run = 1'b0;
    endtask

    task automatic test_extra();
        logic [3:0] exp_ph [5];
        logic [3:0] ph;
        exp_ph = '{P_F, P_F, P_E1, P_E2, P_F};
        do_reset();
        run = 1'b1;
        ir_op = OP_LDA;
        extra = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            ph = {halted, exec2, exec1, fetch};
            n_checks++;
            if (ph !== exp_ph[i]) begin
                n_fail++;
                $display("FAIL extra_phase[%0d]: got %b expected %b", i, ph, exp_ph[i]);
            end
            if (i == 3) begin
                n_checks++;
                if (instr_cnt !== 16'd0) begin
                    n_fail++;
                    $display("FAIL extra_early_retire: got %0d expected 0", instr_cnt);
                end
            end
            $display("test_extra cycle %0d: phase=%b ins=%0d", i, ph, instr_cnt);
        end
        n_checks++;
        if (instr_cnt !== 16'd1 || cycle_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL extra_counts: got ins=%0d cyc=%0d expected 1 4", instr_cnt, cycle_cnt);
        end
        run = 1'b0;
        extra = 1'b0;
    endtask

    task automatic test_step();
        logic [3:0] exp_ph [10];
        logic [3:0] exp2 [4];
        logic [3:0] ph;
        exp_ph = '{P_F, P_F, P_E1, P_I, P_I, P_I, P_I, P_I, P_I, P_I};
        exp2 = '{P_I, P_F, P_F, P_E1};
        do_reset();
        ir_op = OP_LDI;
        extra = 1'b0;
        step = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            ph = {halted, exec2, exec1, fetch};
            n_checks++;
            if (ph !== exp_ph[i]) begin
                n_fail++;
                $display("FAIL step_hold[%0d]: got %b expected %b", i, ph, exp_ph[i]);
            end
            $display("test_step held cycle %0d: phase=%b", i, ph);
        end
        n_checks++;
        if (instr_cnt !== 16'd1 || cycle_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL step_one: got ins=%0d cyc=%0d expected 1 3", instr_cnt, cycle_cnt);
        end
        step = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            step = 1'b1;
            ph = {halted, exec2, exec1, fetch};
            n_checks++;
            if (ph !== exp2[i]) begin
                n_fail++;
                $display("FAIL step_second[%0d]: got %b expected %b", i, ph, exp2[i]);
            end
            $display("test_step second cycle %0d: phase=%b", i, ph);
        end
        tick();
        ph = {halted, exec2, exec1, fetch};
        n_checks++;
        if (ph !== P_I || instr_cnt !== 16'd2 || cycle_cnt !== 16'd6) begin
            n_fail++;
            $display("FAIL step_two: got phase=%b ins=%0d cyc=%0d expected %b 2 6", ph, instr_cnt, cycle_cnt, P_I);
        end
        step = 1'b0;
    endtask

    task automatic test_run_drop();
        logic [3:0] exp_ph [6];
        logic [3:0] ph;
        exp_ph = '{P_F, P_F, P_E1, P_E2, P_I, P_I};
        do_reset();
        run = 1'b1;
        ir_op = OP_LDA;
        extra = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            // RUN falls while the EXTRA instruction sits in EXEC1.
            if (i == 2) run = 1'b0;
            ph = {halted, exec2, exec1, fetch};
            n_checks++;
            if (ph !== exp_ph[i]) begin
                n_fail++;
                $display("FAIL drop_phase[%0d]: got %b expected %b", i, ph, exp_ph[i]);
            end
            $display("test_run_drop cycle %0d: phase=%b", i, ph);
        end
        n_checks++;
        if (instr_cnt !== 16'd1 || cycle_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL drop_counts: got ins=%0d cyc=%0d expected 1 4", instr_cnt, cycle_cnt);
        end
        extra = 1'b0;
    endtask

    task automatic test_reset_override();
        logic [3:0] ph;
        do_reset();
        run = 1'b1;
        ir_op = OP_LDA;
        extra = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        ph = {halted, exec2, exec1, fetch};
        n_checks++;
        if (ph !== P_E2) begin
            n_fail++;
            $display("FAIL ovr_reach_exec2: got %b expected %b", ph, P_E2);
        end
        rst = 1'b1;
        tick();
        ph = {halted, exec2, exec1, fetch};
        n_checks++;
        if (ph !== P_I || ir_load !== 1'b0 || cycle_cnt !== 16'd0 || instr_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL ovr_exec2: got phase=%b irl=%b cyc=%0d ins=%0d expected all 0", ph, ir_load, cycle_cnt, instr_cnt);
        end
        $display("test_reset_override exec2: phase=%b", ph);
        rst = 1'b0;
        ir_op = OP_STP;
        extra = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        ph = {halted, exec2, exec1, fetch};
        n_checks++;
        if (ph !== P_H || cycle_cnt !== 16'd3 || instr_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL ovr_reach_halt: got phase=%b cyc=%0d ins=%0d expected %b 3 0", ph, cycle_cnt, instr_cnt, P_H);
        end
        rst = 1'b1;
        tick();
        ph = {halted, exec2, exec1, fetch};
        n_checks++;
        if (ph !== P_I || ir_load !== 1'b0 || cycle_cnt !== 16'd0 || instr_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL ovr_halt: got phase=%b irl=%b cyc=%0d ins=%0d expected all 0", ph, ir_load, cycle_cnt, instr_cnt);
        end
        $display("test_reset_override halt: phase=%b", ph);
        rst = 1'b0;
        run = 1'b0;
        ir_op = OP_LDI;
    endtask

    task automatic test_saturation();
        sat_rst = 1'b1;
        tick();
        sat_rst = 1'b0;
        sat_run = 1'b1;
        ir_op = OP_LDI;
        extra = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (i == 12) begin
                n_checks++;
                if (sat_instr_cnt !== 4'd3 || sat_cycle_cnt !== 4'd11) begin
                    n_fail++;
                    $display("FAIL sat_mid: got ins=%0d cyc=%0d expected 3 11", sat_instr_cnt, sat_cycle_cnt);
                end
            end
            if (i == 17) begin
                n_checks++;
                if (sat_cycle_cnt !== 4'd15) begin
                    n_fail++;
                    $display("FAIL sat_cycle_reach: got %0d expected 15", sat_cycle_cnt);
                end
            end
            if (i % 12 == 0) begin
                $display("test_saturation cycle %0d: ins=%0d cyc=%0d", i, sat_instr_cnt, sat_cycle_cnt);
            end
        end
        n_checks++;
        if (sat_instr_cnt !== 4'd15 || sat_cycle_cnt !== 4'd15) begin
            n_fail++;
            $display("FAIL sat_final: got ins=%0d cyc=%0d expected 15 15", sat_instr_cnt, sat_cycle_cnt);
        end
        n_checks++;
        if (sat_halted !== 1'b0 || {sat_fetch, sat_exec1, sat_exec2} === 3'b000) begin
            n_fail++;
            $display("FAIL sat_running: got halted=%b strobes=%b expected running", sat_halted, {sat_fetch, sat_exec1, sat_exec2});
        end
        sat_run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run_program();
        test_back_to_back();
        test_extra();
        test_step();
        test_run_drop();
        test_reset_override();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
